// File: rtl/ctrl_comp_serial_pkg.sv
// Shared definitions for the serial nibble comparator: FSM state encoding
// and the default operand size in nibbles.
package ctrl_comp_serial_pkg;

    localparam int NIBBLES_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/ctrl_comp_serial_comp4bits.sv
// Combinational 4-bit unsigned magnitude comparator; exactly one output is
// high for any pair of inputs.
module comp4bits (
    input  logic [3:0] X,
    input  logic [3:0] Y,
    output logic       igual,
    output logic       maior,
    output logic       menor
);

    assign igual = (X == Y);
    assign maior = (X > Y);
    assign menor = (X < Y);

endmodule

// File: rtl/ctrl_comp_serial.sv
// Serial magnitude comparator: walks two NIBBLES-wide operands one nibble per
// clock, MSB first, through a single comp4bits, stopping at the first difference.
module ctrl_comp_serial
    import ctrl_comp_serial_pkg::*;
#(
    parameter int NIBBLES = NIBBLES_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] A,
    input  logic [4*NIBBLES-1:0] B,
    output logic                 busy,
    output logic                 done,
    output logic                 igual,
    output logic                 maior,
    output logic                 menor
);

    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIBBLES - 1);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

    state_e          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [W-1:0]    aReg_q, aReg_d;
    logic [W-1:0]    bReg_q, bReg_d;
    logic            igual_q, igual_d;
    logic            maior_q, maior_d;
    logic            menor_q, menor_d;

    logic [3:0]      nibA, nibB;
    logic            cmpIgual, cmpMaior, cmpMenor;

    // Operands shift left by a nibble per equal step, so the nibble under
    // test is always the top one and no wide mux is needed.
    assign nibA = aReg_q[W-1 -: 4];
    assign nibB = bReg_q[W-1 -: 4];

    comp4bits uComp (
        .X     (nibA),
        .Y     (nibB),
        .igual (cmpIgual),
        .maior (cmpMaior),
        .menor (cmpMenor)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            aReg_q  <= '0;
            bReg_q  <= '0;
            igual_q <= 1'b0;
            maior_q <= 1'b0;
            menor_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            aReg_q  <= aReg_d;
            bReg_q  <= bReg_d;
            igual_q <= igual_d;
            maior_q <= maior_d;
            menor_q <= menor_d;
        end
    end

    // A start in DONE is accepted just like in IDLE, giving gapless
    // back-to-back operations; start during RUN is ignored.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        aReg_d  = aReg_q;
        bReg_d  = bReg_q;
        igual_d = igual_q;
        maior_d = maior_q;
        menor_d = menor_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    aReg_d  = A;
                    bReg_d  = B;
                    idx_d   = IDX_LAST;
                    igual_d = 1'b0;
                    maior_d = 1'b0;
                    menor_d = 1'b0;
                    state_d = RUN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end

            RUN: begin
                if (!cmpIgual) begin
                    igual_d = 1'b0;
                    maior_d = cmpMaior;
                    menor_d = cmpMenor;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    igual_d = 1'b1;
                    maior_d = 1'b0;
                    menor_d = 1'b0;
                    state_d = DONE;
                end else begin
                    idx_d  = idx_q - IDX_ONE;
                    aReg_d = aReg_q << 4;
                    bReg_d = bReg_q << 4;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign igual = igual_q;
    assign maior = maior_q;
    assign menor = menor_q;

endmodule
